// File: rtl/aes_pkg.sv
// Shared AES definitions: block type, round count and the CTR scheduler state encoding.
package aes_pkg;

   typedef logic [127:0] block_t;

   localparam int unsigned AES256_ROUNDS = 14;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_EMIT  = 3'd4
   } ctr_sched_state_e;

endpackage

// File: rtl/aes_ctr_sched_if.sv
// Data-side valid/ready streams of the CTR scheduler: din into the scheduler, dout out of it.
interface aes_ctr_sched_if;
   import aes_pkg::*;

   logic   din_valid;
   logic   din_ready;
   block_t din;
   logic   dout_valid;
   logic   dout_ready;
   block_t dout;

   modport slave (
      input  din_valid, din, dout_ready,
      output din_ready, dout_valid, dout
   );

   modport master (
      output din_valid, din, dout_ready,
      input  din_ready, dout_valid, dout
   );

endinterface

// File: rtl/aes_ctr_inc.sv
// Increments the low counter field; carry_o flags the all-ones to zero wrap.
module aes_ctr_inc #(
   parameter int unsigned CTR_W = 32
) (
   input  logic [CTR_W-1:0] ctr_i,
   output logic [CTR_W-1:0] ctr_o,
   output logic             carry_o
);

   always_comb begin
      {carry_o, ctr_o} = {1'b0, ctr_i} + {{CTR_W{1'b0}}, 1'b1};
   end

endmodule

// File: rtl/aes_ctr_sched.sv
// AES-256 CTR sequencer: owns the counter block, drives the block core, XORs keystream
// with input data and holds the result in a one-entry output buffer.
module aes_ctr_sched
   import aes_pkg::*;
#(
   parameter int unsigned CTR_W    = 32,
   parameter int unsigned WDOG_CYC = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            key_ready,
   input  logic            iv_load,
   input  block_t          iv,
   aes_ctr_sched_if.slave  bus,
   output logic            core_start,
   output block_t          core_block,
   input  logic            core_done,
   input  block_t          core_ks,
   output logic            busy,
   output logic            ctr_wrap,
   output logic            err_tmo
);

   localparam int unsigned WDOG_W = $clog2(WDOG_CYC);

   ctr_sched_state_e  state_q, state_d;
   block_t            ctr_q, ctr_d;
   block_t            data_q, data_d;
   block_t            ks_q, ks_d;
   block_t            out_q, out_d;
   logic              out_vld_q, out_vld_d;
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic              wrap_q, wrap_d;
   logic              tmo_q, tmo_d;
   logic [CTR_W-1:0]  ctr_lo_inc;
   logic              ctr_carry;
   logic              out_full;

   aes_ctr_inc #(.CTR_W(CTR_W)) u_inc (
      .ctr_i   (ctr_q[CTR_W-1:0]),
      .ctr_o   (ctr_lo_inc),
      .carry_o (ctr_carry)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ctr_q     <= '0;
         data_q    <= '0;
         ks_q      <= '0;
         out_q     <= '0;
         out_vld_q <= 1'b0;
         wdog_q    <= '0;
         wrap_q    <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ctr_q     <= ctr_d;
         data_q    <= data_d;
         ks_q      <= ks_d;
         out_q     <= out_d;
         out_vld_q <= out_vld_d;
         wdog_q    <= wdog_d;
         wrap_q    <= wrap_d;
         tmo_q     <= tmo_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      ctr_d         = ctr_q;
      data_d        = data_q;
      ks_d          = ks_q;
      out_d         = out_q;
      out_vld_d     = out_vld_q;
      wdog_d        = wdog_q;
      wrap_d        = wrap_q;
      tmo_d         = tmo_q;
      core_start    = 1'b0;
      bus.din_ready = 1'b0;
      out_full      = out_vld_q & ~bus.dout_ready;

      // A block leaving this cycle frees the buffer, so EMIT never overwrites live data.
      if (bus.dout_ready) out_vld_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (iv_load) begin
               ctr_d   = iv;
               state_d = ST_ARMED;
            end
         end
         ST_ARMED: begin
            bus.din_ready = key_ready & ~out_full;
            if (bus.din_valid && bus.din_ready) begin
               data_d  = bus.din;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            core_start = 1'b1;
            wdog_d     = '0;
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            wdog_d = wdog_q + WDOG_W'(1);
            if (core_done) begin
               ks_d    = core_ks;
               state_d = ST_EMIT;
            end else if (wdog_q == WDOG_W'(WDOG_CYC - 1)) begin
               tmo_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_EMIT: begin
            out_d              = data_q ^ ks_q;
            out_vld_d          = 1'b1;
            ctr_d[CTR_W-1:0]   = ctr_lo_inc;
            if (ctr_carry) wrap_d = 1'b1;
            state_d            = ST_ARMED;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign core_block     = ctr_q;
   assign bus.dout_valid = out_vld_q;
   assign bus.dout       = out_q;
   assign busy           = (state_q != ST_IDLE);
   assign ctr_wrap       = wrap_q;
   assign err_tmo        = tmo_q;

endmodule

// File: tb/tb_aes_ctr_sched.sv
// Scoreboard bench for aes_ctr_sched with a fixed-latency XOR-mask core model.
module tb_aes_ctr_sched;
   import aes_pkg::*;

   localparam block_t KS_MASK = {16{8'hA5}};
   localparam int     L_CORE  = 15;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   logic   key_ready = 1'b1;
   logic   iv_load = 1'b0;
   block_t iv = '0;
   logic   core_start;
   block_t core_block;
   logic   core_done = 1'b0;
   block_t core_ks = '0;
   logic   busy, ctr_wrap, err_tmo;

   aes_ctr_sched_if bus();

   aes_ctr_sched #(.CTR_W(32), .WDOG_CYC(64)) dut (
      .clk        (clk),
      .rst        (rst),
      .key_ready  (key_ready),
      .iv_load    (iv_load),
      .iv         (iv),
      .bus        (bus),
      .core_start (core_start),
      .core_block (core_block),
      .core_done  (core_done),
      .core_ks    (core_ks),
      .busy       (busy),
      .ctr_wrap   (ctr_wrap),
      .err_tmo    (err_tmo)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: records every dout and din handshake with its cycle number.
   block_t got_blk[$];
   int     got_cyc[$];
   int     hs_cyc[$];

   always @(negedge clk) begin
      if (bus.dout_valid && bus.dout_ready) begin
         got_blk.push_back(bus.dout);
         got_cyc.push_back(cyc);
      end
      if (bus.din_valid && bus.din_ready) hs_cyc.push_back(cyc);
   end

   // Core model: done in the 15th cycle after the start cycle; mode 1 never answers.
   int     core_mode = 0;
   int     cm_cnt = 0;
   bit     cm_pend = 1'b0;
   block_t cm_blk = '0;
   int     start_cyc = 0;
   int     start_n = 0;

   always @(negedge clk) begin
      core_done = 1'b0;
      if (cm_pend) begin
         cm_cnt++;
         if (cm_cnt == L_CORE) begin
            core_done = 1'b1;
            core_ks   = cm_blk ^ KS_MASK;
            cm_pend   = 1'b0;
         end
      end
      if (core_start) begin
         start_cyc = cyc;
         start_n++;
         cm_blk = core_block;
         if (core_mode == 0) begin
            cm_pend = 1'b1;
            cm_cnt  = 0;
         end
      end
   end

   block_t exp_q[$];
   block_t ctr_m;
   bit     wrap_m;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic adv_ctr;
      logic [31:0] lo;
      lo = ctr_m[31:0];
      if (lo == 32'hFFFF_FFFF) wrap_m = 1'b1;
      ctr_m[31:0] = lo + 32'd1;
   endtask

   task automatic do_reset;
      rst           = 1'b1;
      bus.din_valid = 1'b0;
      bus.dout_ready = 1'b1;
      iv_load       = 1'b0;
      tick(2);
      rst    = 1'b0;
      ctr_m  = '0;
      wrap_m = 1'b0;
      exp_q.delete();
   endtask

   task automatic load_iv(input block_t v);
      iv      = v;
      iv_load = 1'b1;
      tick(1);
      iv_load = 1'b0;
      ctr_m   = v;
   endtask

   task automatic send_block(input block_t d, input bit exp_out);
      bit ok;
      ok            = 1'b0;
      bus.din       = d;
      bus.din_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.din_ready) begin
            ok = 1'b1;
            break;
         end
      end
      tick(1);
      bus.din_valid = 1'b0;
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL din_accept: din_ready never seen, got 0 expected 1");
      end else if (exp_out) begin
         exp_q.push_back(ctr_m ^ d ^ KS_MASK);
         adv_ctr();
      end
   endtask

   task automatic wait_got(input int target);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (got_blk.size() >= target) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL dout_count: got %0d blocks expected %0d", got_blk.size(), target);
      end
      tick(1);
   endtask

   task automatic wait_start(input int sn);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (start_n != sn) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL core_start_seen: got 0 expected 1");
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.din_valid = 1'b0;
      bus.dout_ready = 1'b1;
      tick(3);
      @(negedge clk);
      n_tests++;
      if ({busy, bus.din_ready, bus.dout_valid, core_start, ctr_wrap, err_tmo} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 000000",
                  {busy, bus.din_ready, bus.dout_valid, core_start, ctr_wrap, err_tmo});
      end
      n_tests++;
      if (core_block !== '0) begin
         n_fail++;
         $display("FAIL reset_ctr: got %h expected 0", core_block);
      end
      n_tests++;
      if (bus.dout !== '0) begin
         n_fail++;
         $display("FAIL reset_dout: got %h expected 0", bus.dout);
      end
      tick(1);
      rst = 1'b0;
   endtask

   task automatic test_single;
      int     gb, hb;
      block_t e;
      do_reset();
      load_iv('0);
      gb = got_blk.size();
      hb = hs_cyc.size();
      send_block('0, 1'b1);
      wait_got(gb + 1);
      if (got_blk.size() > gb && hs_cyc.size() > hb) begin
         e = exp_q.pop_front();
         n_tests++;
         if (got_blk[gb] !== e) begin
            n_fail++;
            $display("FAIL single_dout: got %h expected %h", got_blk[gb], e);
         end
         n_tests++;
         if (got_cyc[gb] - hs_cyc[hb] !== 18) begin
            n_fail++;
            $display("FAIL single_latency: got %0d expected 18", got_cyc[gb] - hs_cyc[hb]);
         end
      end
      n_tests++;
      if (cm_blk !== 128'h0) begin
         n_fail++;
         $display("FAIL single_core_block: got %h expected 0", cm_blk);
      end
      n_tests++;
      if (core_block !== ctr_m) begin
         n_fail++;
         $display("FAIL single_ctr: got %h expected %h", core_block, ctr_m);
      end
   endtask

   task automatic test_stream;
      int     gb;
      block_t ivs, e;
      ivs = {96'h0123_4567_89AB_CDEF_FEDC_BA98, 32'h0000_0010};
      do_reset();
      load_iv(ivs);
      gb = got_blk.size();
      for (int i = 0; i < 4; i++) send_block('0, 1'b1);
      wait_got(gb + 4);
      for (int i = 0; i < 4; i++) begin
         if (got_blk.size() > gb + i) begin
            e = exp_q.pop_front();
            n_tests++;
            if (got_blk[gb + i] !== e) begin
               n_fail++;
               $display("FAIL stream_dout%0d: got %h expected %h", i, got_blk[gb + i], e);
            end
         end
      end
      n_tests++;
      if (core_block[127:32] !== ivs[127:32]) begin
         n_fail++;
         $display("FAIL stream_nonce: got %h expected %h", core_block[127:32], ivs[127:32]);
      end
      n_tests++;
      if (core_block !== ctr_m) begin
         n_fail++;
         $display("FAIL stream_ctr: got %h expected %h", core_block, ctr_m);
      end
   endtask

   task automatic test_wrap;
      int     gb;
      block_t ivw, e;
      ivw = {96'hCAFE_F00D_1234_5678_9ABC_DEF0, 32'hFFFF_FFFF};
      do_reset();
      load_iv(ivw);
      gb = got_blk.size();
      send_block({4{32'h1111_2222}}, 1'b1);
      wait_got(gb + 1);
      n_tests++;
      if (ctr_wrap !== wrap_m) begin
         n_fail++;
         $display("FAIL wrap_flag: got %b expected %b", ctr_wrap, wrap_m);
      end
      n_tests++;
      if (core_block !== ctr_m) begin
         n_fail++;
         $display("FAIL wrap_ctr: got %h expected %h", core_block, ctr_m);
      end
      send_block({4{32'h3333_4444}}, 1'b1);
      wait_got(gb + 2);
      for (int i = 0; i < 2; i++) begin
         if (got_blk.size() > gb + i) begin
            e = exp_q.pop_front();
            n_tests++;
            if (got_blk[gb + i] !== e) begin
               n_fail++;
               $display("FAIL wrap_dout%0d: got %h expected %h", i, got_blk[gb + i], e);
            end
         end
      end
      n_tests++;
      if (ctr_wrap !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_sticky: got %b expected 1", ctr_wrap);
      end
   endtask

   task automatic test_backpressure;
      int     gb, acc, unstable;
      bit     hs, have_held;
      block_t held, e;
      logic   rdy_end;
      do_reset();
      load_iv({96'h5555_AAAA_5555_AAAA_5555_AAAA, 32'h0000_0100});
      gb        = got_blk.size();
      acc       = 0;
      unstable  = 0;
      have_held = 1'b0;
      held      = '0;
      rdy_end   = 1'b1;
      bus.dout_ready = 1'b0;
      bus.din        = {4{32'h0BAD_0000}};
      bus.din_valid  = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         hs      = bus.din_valid & bus.din_ready;
         rdy_end = bus.din_ready;
         if (bus.dout_valid) begin
            if (!have_held) begin
               held      = bus.dout;
               have_held = 1'b1;
            end else if (bus.dout !== held) begin
               unstable++;
            end
         end
         tick(1);
         if (hs) begin
            exp_q.push_back(ctr_m ^ bus.din ^ KS_MASK);
            adv_ctr();
            acc++;
            bus.din = bus.din + 128'd1;
         end
      end
      n_tests++;
      if (acc !== 1) begin
         n_fail++;
         $display("FAIL bp_accepted: got %0d expected 1", acc);
      end
      n_tests++;
      if (rdy_end !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_din_ready: got %b expected 0", rdy_end);
      end
      n_tests++;
      if (have_held !== 1'b1 || unstable !== 0) begin
         n_fail++;
         $display("FAIL bp_dout_stable: got held=%b changes=%0d expected held=1 changes=0",
                  have_held, unstable);
      end
      if (exp_q.size() > 0) begin
         e = exp_q[0];
         n_tests++;
         if (held !== e) begin
            n_fail++;
            $display("FAIL bp_held_value: got %h expected %h", held, e);
         end
      end
      bus.dout_ready = 1'b1;
      for (int i = 0; i < 200 && acc < 3; i++) begin
         @(negedge clk);
         hs = bus.din_valid & bus.din_ready;
         tick(1);
         if (hs) begin
            exp_q.push_back(ctr_m ^ bus.din ^ KS_MASK);
            adv_ctr();
            acc++;
            bus.din = bus.din + 128'd1;
            if (acc == 3) bus.din_valid = 1'b0;
         end
      end
      bus.din_valid = 1'b0;
      wait_got(gb + 3);
      tick(30);
      n_tests++;
      if (got_blk.size() - gb !== 3) begin
         n_fail++;
         $display("FAIL bp_block_count: got %0d expected 3", got_blk.size() - gb);
      end
      for (int i = 0; i < 3; i++) begin
         if (got_blk.size() > gb + i && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (got_blk[gb + i] !== e) begin
               n_fail++;
               $display("FAIL bp_dout%0d: got %h expected %h", i, got_blk[gb + i], e);
            end
         end
      end
   endtask

   task automatic test_timeout;
      int     gb, sn, seen;
      block_t ivt;
      ivt = {96'h7777_8888_9999_AAAA_BBBB_CCCC, 32'h0000_0042};
      do_reset();
      core_mode = 1;
      load_iv(ivt);
      gb = got_blk.size();
      sn = start_n;
      send_block({4{32'hFEED_BEEF}}, 1'b0);
      wait_start(sn);
      tick(3);
      iv      = ~ivt;
      iv_load = 1'b1;
      tick(1);
      iv_load = 1'b0;
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b1 || core_block !== ivt) begin
         n_fail++;
         $display("FAIL busy_iv_load: got busy=%b ctr=%h expected busy=1 ctr=%h", busy, core_block, ivt);
      end
      seen = -1;
      for (int i = 0; i < 120; i++) begin
         if (err_tmo === 1'b1) begin
            seen = cyc;
            break;
         end
         @(negedge clk);
      end
      // 64 cycles counted from the edge that samples core_start.
      n_tests++;
      if (seen - start_cyc !== 65) begin
         n_fail++;
         $display("FAIL tmo_cycle: got %0d expected 65", seen - start_cyc);
      end
      n_tests++;
      if (busy !== 1'b0 || bus.dout_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_idle: got busy=%b dout_valid=%b expected 0 0", busy, bus.dout_valid);
      end
      tick(5);
      n_tests++;
      if (got_blk.size() !== gb || err_tmo !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_no_dout: got blocks=%0d err=%b expected %0d 1", got_blk.size(), err_tmo, gb);
      end
      core_mode = 0;
   endtask

   task automatic test_reset_mid_wait;
      int gb, sn;
      do_reset();
      core_mode = 0;
      load_iv({96'h1357_9BDF_2468_ACE0_1122_3344, 32'h0000_0007});
      gb = got_blk.size();
      sn = start_n;
      send_block({4{32'h0F0F_0F0F}}, 1'b0);
      wait_start(sn);
      tick(1);
      for (int i = 0; i < 20 && cyc < start_cyc + 5; i++) tick(1);
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midwait_busy: got %b expected 1", busy);
      end
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({busy, bus.din_ready, bus.dout_valid, core_start, ctr_wrap, err_tmo} !== 6'b0
          || core_block !== '0 || bus.dout !== '0) begin
         n_fail++;
         $display("FAIL midwait_outputs: got flags=%b ctr=%h dout=%h expected all 0",
                  {busy, bus.din_ready, bus.dout_valid, core_start, ctr_wrap, err_tmo},
                  core_block, bus.dout);
      end
      tick(25);
      n_tests++;
      if (got_blk.size() !== gb || busy !== 1'b0 || bus.dout_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL midwait_late_done: got blocks=%0d busy=%b dout_valid=%b expected %0d 0 0",
                  got_blk.size(), busy, bus.dout_valid, gb);
      end
   endtask

   initial begin
      bus.din_valid  = 1'b0;
      bus.din        = '0;
      bus.dout_ready = 1'b1;
      test_reset();
      test_single();
      test_stream();
      test_wrap();
      test_backpressure();
      test_timeout();
      test_reset_mid_wait();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

endmodule
